// File: rtl/pc_update_unit_pkg.sv
// rtl/pc_update_unit_pkg.sv - shared state encoding and constants for the PC update unit
package pc_update_unit_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_target_adder.sv
// rtl/pc_target_adder.sv - sequential and branch/jump target address adders
module pc_target_adder
    import pc_update_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] offset_ext,
    output logic [31:0] pc_plus4,
    output logic [31:0] target
);

    // Both sums wrap silently modulo 2^32.
    assign pc_plus4 = pc + PC_STEP;
    assign target   = pc_plus4 + offset_ext;

endmodule

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - program counter with stall handling and deferred redirect
module pc_update_unit
    import pc_update_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [31:0]            OFFSET_EXT,
    input  logic                   JUMP,
    input  logic                   BRANCH_EQ,
    input  logic                   BRANCH_NE,
    input  logic                   ZERO,
    input  logic                   BUSYWAIT,
    output logic [31:0]            PC,
    output logic [31:0]            PC_PLUS4,
    output logic                   REDIRECT_PENDING,
    output logic [STALL_CNT_W-1:0] STALL_CYCLES
);

    pc_state_t   state;
    logic [31:0] target;
    logic [31:0] latched_target;
    logic        take;

    pc_target_adder u_adder (
        .pc         (PC),
        .offset_ext (OFFSET_EXT),
        .pc_plus4   (PC_PLUS4),
        .target     (target)
    );

    assign take = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PC               <= RESET_PC;
            REDIRECT_PENDING <= 1'b0;
            latched_target   <= 32'd0;
            STALL_CYCLES     <= '0;
            state            <= ST_INIT;
        end else begin
            if (BUSYWAIT && (state != ST_INIT) && (STALL_CYCLES != '1)) begin
                STALL_CYCLES <= STALL_CYCLES + 1'b1;
            end

            case (state)
                ST_INIT: begin
                    // Hold PC one cycle so RESET_PC itself is fetched.
                    state <= BUSYWAIT ? ST_STALL : ST_RUN;
                end
                ST_RUN, ST_STALL: begin
                    if (BUSYWAIT) begin
                        state <= ST_STALL;
                        // First taken decision while stalled wins; the pending
                        // check comes first so X controls are never consulted.
                        if (!REDIRECT_PENDING && take) begin
                            latched_target   <= target;
                            REDIRECT_PENDING <= 1'b1;
                        end
                    end else begin
                        state            <= ST_RUN;
                        REDIRECT_PENDING <= 1'b0;
                        if (REDIRECT_PENDING) begin
                            PC <= latched_target;
                        end else begin
                            PC <= take ? target : PC_PLUS4;
                        end
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - self-checking bench for pc_update_unit against a behavioural model
module tb_pc_update_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] OFFSET_EXT;
    logic        JUMP, BRANCH_EQ, BRANCH_NE, ZERO, BUSYWAIT;
    logic [31:0] PC, PC_PLUS4, PC_4, PC_PLUS4_4;
    logic        REDIRECT_PENDING, REDIRECT_PENDING_4;
    logic [15:0] STALL_CYCLES;
    logic [3:0]  STALL_CYCLES_4;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc, m_tgt;
    bit          m_pend, m_init;
    int          m_cnt;

    always #5 CLK = ~CLK;

    pc_update_unit #(.RESET_PC(32'h0), .STALL_CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .OFFSET_EXT(OFFSET_EXT), .JUMP(JUMP),
        .BRANCH_EQ(BRANCH_EQ), .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .BUSYWAIT(BUSYWAIT),
        .PC(PC), .PC_PLUS4(PC_PLUS4), .REDIRECT_PENDING(REDIRECT_PENDING),
        .STALL_CYCLES(STALL_CYCLES)
    );

    pc_update_unit #(.RESET_PC(32'h0), .STALL_CNT_W(4)) dut4 (
        .CLK(CLK), .RESET(RESET), .OFFSET_EXT(OFFSET_EXT), .JUMP(JUMP),
        .BRANCH_EQ(BRANCH_EQ), .BRANCH_NE(BRANCH_NE), .ZERO(ZERO), .BUSYWAIT(BUSYWAIT),
        .PC(PC_4), .PC_PLUS4(PC_PLUS4_4), .REDIRECT_PENDING(REDIRECT_PENDING_4),
        .STALL_CYCLES(STALL_CYCLES_4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_pend = 0; m_cnt = 0; m_init = 1;
    endtask

    // Architectural view: stall freezes PC, first taken target is remembered,
    // and on release the remembered target beats anything decided that cycle.
    task automatic model_edge();
        logic        take;
        logic [31:0] seq, tgt;
        take = JUMP | (BRANCH_EQ & ZERO) | (BRANCH_NE & ~ZERO);
        seq  = m_pc + 32'd4;
        tgt  = seq + OFFSET_EXT;
        if (m_init) begin
            m_init = 0;
        end else if (BUSYWAIT) begin
            if (m_cnt < 65535) m_cnt++;
            if (!m_pend && take === 1'b1) begin
                m_pend = 1;
                m_tgt  = tgt;
            end
        end else begin
            if (m_pend) m_pc = m_tgt;
            else        m_pc = (take === 1'b1) ? tgt : seq;
            m_pend = 0;
        end
    endtask

    task automatic check_all();
        chk("pc", PC, m_pc);
        chk("pc_plus4", PC_PLUS4, m_pc + 32'd4);
        chk("redirect_pending", {31'd0, REDIRECT_PENDING}, {31'd0, m_pend});
        chk("stall_cycles", {16'd0, STALL_CYCLES}, m_cnt[31:0]);
        chk("stall_cycles_w4", {28'd0, STALL_CYCLES_4}, (m_cnt > 15) ? 32'd15 : m_cnt[31:0]);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        JUMP = 0; BRANCH_EQ = 0; BRANCH_NE = 0; ZERO = 0; BUSYWAIT = 0; OFFSET_EXT = 32'h0;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        idle_inputs();
        JUMP = 1;
        OFFSET_EXT = addr - m_pc - 32'd4;
        cycle();
        JUMP = 0;
    endtask

    initial begin
        RESET = 1;
        idle_inputs();
        model_reset();
        #12;
        check_all();
        chk("reset_pc", PC, 32'h0);
        @(negedge CLK);
        RESET = 0;

        // INIT hold then sequential fetch: 0,0,4,8,12
        cycle(); chk("init_hold", PC, 32'h0);
        cycle(); chk("seq_4", PC, 32'h4);
        cycle(); chk("seq_8", PC, 32'h8);
        cycle(); chk("seq_12", PC, 32'hC);

        goto_pc(32'h20);
        BRANCH_EQ = 1; ZERO = 1; OFFSET_EXT = 32'hFFFF_FFF8;
        cycle(); chk("beq_backward", PC, 32'h1C);
        goto_pc(32'h20);
        BRANCH_EQ = 1; ZERO = 0; OFFSET_EXT = 32'hFFFF_FFF8;
        cycle(); chk("beq_not_taken", PC, 32'h24);

        goto_pc(32'h10);
        JUMP = 1; OFFSET_EXT = 32'h40;
        cycle(); chk("jump_fwd", PC, 32'h54);
        goto_pc(32'h10);
        JUMP = 1; BRANCH_NE = 1; ZERO = 1; OFFSET_EXT = 32'h40;
        cycle(); chk("jump_and_bne", PC, 32'h54);

        goto_pc(32'h30);
        BUSYWAIT = 1; JUMP = 1; OFFSET_EXT = 32'h8;
        cycle();
        JUMP = 0;
        cycle();
        cycle();
        chk("stall_hold", PC, 32'h30);
        chk("stall_pending", {31'd0, REDIRECT_PENDING}, 32'd1);
        BUSYWAIT = 0;
        cycle();
        chk("stall_redirect", PC, 32'h3C);
        chk("stall_count3", {16'd0, STALL_CYCLES}, 32'd3);

        // Later decisions and X controls during a pending stall are ignored
        BUSYWAIT = 1; JUMP = 1; OFFSET_EXT = 32'h100;
        cycle();
        JUMP = 1'bx; BRANCH_EQ = 1'bx; BRANCH_NE = 1'bx; ZERO = 1'bx; OFFSET_EXT = 'x;
        cycle();
        JUMP = 0; BRANCH_EQ = 0; BRANCH_NE = 1; ZERO = 0; OFFSET_EXT = 32'h200;
        cycle();
        idle_inputs();
        cycle();
        chk("first_redirect_wins", PC, 32'h3C + 32'h4 + 32'h100);

        // Sub-cycle busywait glitch has no effect
        BUSYWAIT = 1; #2; BUSYWAIT = 0;
        cycle();

        goto_pc(32'hFFFF_FFFC);
        chk("plus4_wrap", PC_PLUS4, 32'h0);
        cycle(); chk("pc_wrap", PC, 32'h0);

        // Asynchronous reset in the middle of a stall with a redirect pending
        BUSYWAIT = 1; JUMP = 1; OFFSET_EXT = 32'h44;
        cycle();
        @(negedge CLK);
        RESET = 1;
        #1;
        model_reset();
        chk("async_rst_pc", PC, 32'h0);
        chk("async_rst_pending", {31'd0, REDIRECT_PENDING}, 32'd0);
        chk("async_rst_cnt", {16'd0, STALL_CYCLES}, 32'd0);
        idle_inputs();
        @(negedge CLK);
        RESET = 0;
        cycle(); chk("reinit_hold", PC, 32'h0);
        cycle(); chk("reinit_seq", PC, 32'h4);

        BUSYWAIT = 1;
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_w4", {28'd0, STALL_CYCLES_4}, 32'd15);
        chk("count_w16", {16'd0, STALL_CYCLES}, 32'd20);
        BUSYWAIT = 0;
        cycle();

        for (int i = 0; i < 400; i++) begin
            BUSYWAIT   = ($urandom_range(0, 9) < 4);
            JUMP       = ($urandom_range(0, 9) == 0);
            BRANCH_EQ  = ($urandom_range(0, 3) == 0);
            BRANCH_NE  = ($urandom_range(0, 3) == 0);
            ZERO       = $urandom_range(0, 1);
            OFFSET_EXT = {{20{1'b0}}, 12'($urandom_range(0, 1023)), 2'b00} - 32'h800;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
